// File: rtl/adder_wb_collector.sv
`default_nettype none
// ============================================================================
//  Module   : adder_wb_collector
//  Purpose  : Tracks destination registers alongside a fixed-latency adder and
//             buffers its results for valid/ready register-file writeback.
//  Revision : 1.0  initial release
// ============================================================================
module adder_wb_collector #(
    parameter int DEPTH      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [4:0]                    issue_rd,
    input  logic                          flush,
    input  logic [31:0]                   result_in,
    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [4:0]                    wb_rd,
    output logic [31:0]                   wb_data,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = OW + CW;

    logic [DEPTH-1:0]    r_tag_v;
    logic [4:0]          r_tag_rd [DEPTH];
    logic [36:0]         r_mem    [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [OW-1:0]       r_occ;
    logic [4:0]          r_wb_rd;
    logic [31:0]         r_wb_data;

    logic [CW-1:0]       w_inflight;
    logic [SW-1:0]       w_credit_sum;
    logic                w_accept;
    logic                w_capture;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic [AW-1:0]       w_rd_ptr_nxt;
    logic [OW-1:0]       w_occ_nxt;

    always_comb begin
        w_inflight = '0;
        for (int j = 0; j < DEPTH; j++) begin
            w_inflight = w_inflight + CW'(r_tag_v[j]);
        end
    end

    // Credits count both buffered entries and ops still inside the adder, so a
    // capture can never find the buffer full.
    assign w_credit_sum = SW'(r_occ) + SW'(w_inflight);
    assign issue_ready  = (w_credit_sum < SW'(FIFO_DEPTH));
    assign w_accept     = issue_valid & issue_ready;

    assign w_capture    = r_tag_v[DEPTH-1] & (r_tag_rd[DEPTH-1] != 5'd0);
    assign w_full       = (r_occ == OW'(FIFO_DEPTH));
    assign w_push       = w_capture & ~w_full;
    assign wb_valid     = (r_occ != '0);
    assign w_pop        = wb_valid & wb_ready;

    assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    assign w_occ_nxt    = r_occ + OW'(w_push) - OW'(w_pop);

    assign occupancy    = r_occ;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag_v <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                r_tag_rd[j] <= 5'd0;
            end
        end else begin
            // Flush squashes every in-flight op, including the one accepted now.
            r_tag_v[0]  <= w_accept & ~flush;
            r_tag_rd[0] <= issue_rd;
            for (int j = 1; j < DEPTH; j++) begin
                r_tag_v[j]  <= r_tag_v[j-1] & ~flush;
                r_tag_rd[j] <= r_tag_rd[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_tag_rd[DEPTH-1], result_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_wb_rd   <= 5'd0;
            r_wb_data <= 32'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_occ    <= w_occ_nxt;
            // Registered head: a push landing on the next head slot is forwarded
            // because the memory write is not yet visible.
            if (w_occ_nxt != '0) begin
                if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
                    r_wb_rd   <= r_tag_rd[DEPTH-1];
                    r_wb_data <= result_in;
                end else begin
                    {r_wb_rd, r_wb_data} <= r_mem[w_rd_ptr_nxt];
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_capture && w_full));

endmodule
`default_nettype wire

// File: tb/tb_adder_wb_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_wb_collector
//  Purpose  : Self-checking bench; models the adder pipeline and scoreboards
//             the writeback stream against issued ops.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adder_wb_collector;

    localparam int DEPTH      = 3;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [31:0] result_in;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [$clog2(FIFO_DEPTH):0] occupancy;

    adder_wb_collector #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_rd    (issue_rd),
        .flush       (flush),
        .result_in   (result_in),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Adder stand-in: whatever is presented at edge k appears after edge k+DEPTH-1.
    logic [31:0] adder_in;
    logic [31:0] pipe [DEPTH];
    always @(posedge clk) begin
        pipe[0] <= adder_in;
        for (int j = 1; j < DEPTH; j++) pipe[j] <= pipe[j-1];
    end
    assign result_in = pipe[DEPTH-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          edge_no;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic cycle(input logic iv, input logic [4:0] rd, input logic wr,
                         input logic fl, input logic [31:0] d, output logic acc);
        exp_t e;
        issue_valid = iv;
        issue_rd    = rd;
        wb_ready    = wr;
        flush       = fl;
        adder_in    = d;
        #1;
        acc = iv && issue_ready;
        if (wb_valid && wb_ready) begin
            pops++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_pop: got rd=%0d data=%h, required no entry", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    errors++;
                    $display("FAIL wb_pop: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end
            end
        end
        // A flush at this edge kills every op whose capture edge lies beyond it.
        if (fl) begin
            while (sb.size() > 0 && sb[$].edge_no + DEPTH > cyc) void'(sb.pop_back());
        end
        if (acc && !fl && rd != 5'd0) begin
            e.rd      = rd;
            e.data    = d;
            e.edge_no = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic wr);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, wr, 1'b0, $urandom, acc);
    endtask

    task automatic drain(input string tag);
        idle(DEPTH + FIFO_DEPTH + 2, 1'b1);
        checks++;
        if (sb.size() != 0 || wb_valid !== 1'b0 || occupancy !== '0 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d wb_valid=%0b occ=%0d ready=%0b, required 0/0/0/1",
                     tag, sb.size(), wb_valid, occupancy, issue_ready);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0 ||
            issue_ready !== 1'b1 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_state: wb_valid=%0b rd=%0d data=%h ready=%0b occ=%0d, required 0/0/0/1/0",
                     wb_valid, wb_rd, wb_data, issue_ready, occupancy);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic acc;
        cycle(1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_0007, acc);
        for (int i = 0; i < DEPTH - 1; i++) begin
            checks++;
            if (wb_valid !== 1'b0) begin
                errors++;
                $display("FAIL lat_early: wb_valid=%0b after edge %0d, required 0", wb_valid, i);
            end
            idle(1, 1'b1);
        end
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: wb_valid=%0b before capture, required 0", wb_valid);
        end
        idle(1, 1'b1);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'd7 || occupancy !== 1) begin
            errors++;
            $display("FAIL lat_capture: wb_valid=%0b rd=%0d data=%h occ=%0d, required 1/5/7/1",
                     wb_valid, wb_rd, wb_data, occupancy);
        end
        idle(1, 1'b1);
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== 0) begin
            errors++;
            $display("FAIL lat_pop: wb_valid=%0b occ=%0d, required 0/0", wb_valid, occupancy);
        end
        drain("latency");
    endtask

    task automatic test_backpressure();
        logic acc;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 5'(i + 1), 1'b0, 1'b0, $urandom, acc);
            checks++;
            if (acc !== (i < 4)) begin
                errors++;
                $display("FAIL bp_accept: op %0d accepted=%0b, required %0b", i, acc, (i < 4));
            end
            checks++;
            if (issue_ready !== (i < 3)) begin
                errors++;
                $display("FAIL bp_ready: after edge %0d issue_ready=%0b, required %0b", i, issue_ready, (i < 3));
            end
        end
        idle(1, 1'b0);
        checks++;
        if (occupancy !== 4 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: occ=%0d ready=%0b, required 4/0", occupancy, issue_ready);
        end
        idle(1, 1'b1);
        checks++;
        if (occupancy !== 3 || issue_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first_pop: occ=%0d ready=%0b, required 3/1", occupancy, issue_ready);
        end
        drain("backpressure");
    endtask

    task automatic test_x0_discard();
        logic acc;
        int   p0 = pops;
        cycle(1'b1, 5'd0, 1'b1, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd3, 1'b1, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd0, 1'b1, 1'b0, $urandom, acc);
        drain("x0");
        checks++;
        if (pops - p0 !== 1) begin
            errors++;
            $display("FAIL x0_count: writebacks=%0d, required 1", pops - p0);
        end
    endtask

    task automatic test_flush();
        logic acc;
        int   p0 = pops;
        cycle(1'b1, 5'd7, 1'b1, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd8, 1'b1, 1'b0, $urandom, acc);
        cycle(1'b0, 5'd0, 1'b1, 1'b1, $urandom, acc);
        checks++;
        if (issue_ready !== 1'b1 || occupancy !== 0) begin
            errors++;
            $display("FAIL flush_credit: ready=%0b occ=%0d, required 1/0", issue_ready, occupancy);
        end
        drain("flush_mid");
        checks++;
        if (pops - p0 !== 0) begin
            errors++;
            $display("FAIL flush_mid_count: writebacks=%0d, required 0", pops - p0);
        end
        p0 = pops;
        cycle(1'b1, 5'd7, 1'b1, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd8, 1'b1, 1'b0, $urandom, acc);
        idle(1, 1'b1);
        cycle(1'b0, 5'd0, 1'b1, 1'b1, $urandom, acc);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd7) begin
            errors++;
            $display("FAIL flush_capture: wb_valid=%0b rd=%0d, required 1/7", wb_valid, wb_rd);
        end
        drain("flush_cap");
        checks++;
        if (pops - p0 !== 1) begin
            errors++;
            $display("FAIL flush_cap_count: writebacks=%0d, required 1", pops - p0);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        int   nacc = 0;
        int   p0   = pops;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 5'(i + 1), 1'b1, 1'b0, $urandom, acc);
            if (acc) nacc++;
            checks++;
            if (occupancy > 1) begin
                errors++;
                $display("FAIL b2b_occ: occ=%0d after edge %0d, required <=1", occupancy, i);
            end
        end
        drain("b2b");
        checks++;
        if (pops - p0 !== nacc || nacc < 6) begin
            errors++;
            $display("FAIL b2b_count: writebacks=%0d accepts=%0d, required equal and >=6", pops - p0, nacc);
        end
    endtask

    task automatic test_async_reset();
        logic acc;
        cycle(1'b1, 5'd10, 1'b0, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd11, 1'b0, 1'b0, $urandom, acc);
        idle(1, 1'b0);
        cycle(1'b1, 5'd12, 1'b0, 1'b0, $urandom, acc);
        cycle(1'b1, 5'd13, 1'b0, 1'b0, $urandom, acc);
        checks++;
        if (occupancy !== 2 || issue_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_setup: occ=%0d ready=%0b, required 2/0", occupancy, issue_ready);
        end
        issue_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || occupancy !== 0 || issue_ready !== 1'b1 ||
            wb_rd !== 5'd0 || wb_data !== 32'd0) begin
            errors++;
            $display("FAIL arst_immediate: wb_valid=%0b occ=%0d ready=%0b rd=%0d data=%h, required 0/0/1/0/0",
                     wb_valid, occupancy, issue_ready, wb_rd, wb_data);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            idle(1, 1'b1);
            checks++;
            if (wb_valid !== 1'b0 || occupancy !== 0) begin
                errors++;
                $display("FAIL arst_stale: wb_valid=%0b occ=%0d after release cycle %0d, required 0/0",
                         wb_valid, occupancy, i);
            end
        end
        drain("arst");
    endtask

    initial begin
        reset       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        flush       = 1'b0;
        wb_ready    = 1'b0;
        adder_in    = 32'd0;
        test_reset();
        test_latency();
        test_backpressure();
        test_x0_discard();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_wb_collector.md
Name: adder_wb_collector

Overview:
- Consumer end of the pipelined adder's result interface.
- The adder has a fixed latency of DEPTH cycles and no valid or stall signals. This block tracks each issued operation's destination register alongside the adder pipeline.
- It captures `result_in` when that operation emerges and buffers {rd, data} in a FIFO.
- It presents the buffered entries to register-file writeback with a valid/ready handshake.
- It back-pressures issue via credits, so the non-stallable adder can never overflow the buffer.

Parameters:
- DEPTH, 3, adder pipeline depth; must equal the adder's DEPTH (≥1).
- FIFO_DEPTH, 4, writeback buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode is sending an adder op this cycle (opA/opB/i presented to the adder).
- issue_ready  out  1  collector can accept one more op.
- issue_rd  in  5  destination register of the issued op.
- flush  in  1  squash all in-flight (not yet captured) ops.
- result_in  in  32  the adder's result_out.
- wb_valid  out  1  head entry available.
- wb_ready  in  1  register file accepts the head entry.
- wb_rd  out  5  head entry destination.
- wb_data  out  32  head entry data.
- occupancy  out  log2(FIFO_DEPTH)+1  entries currently in the FIFO.

Behaviour:
- Reset (asynchronous, while reset=0):
  - tag line valids cleared; FIFO pointers and occupancy 0; in-flight count 0.
  - outputs: wb_valid=0, wb_rd=0, wb_data=0, issue_ready=1, occupancy=0.
  - an op issued but in flight when reset asserts is lost; no capture occurs after reset releases.
- Issue:
  - An op is accepted at edge k iff issue_valid & issue_ready.
  - The adder registers opA/opB at edge k, so its result appears on result_in after edge k+DEPTH-1.
- Tag line:
  - DEPTH stages of {v, rd}; stage 0 loads {accept, issue_rd} at each edge; stage j loads stage j-1.
  - Stage DEPTH-1 is cycle-aligned with result_in.
- Capture:
  - At edge k+DEPTH, if stage DEPTH-1 has v=1 and rd≠0, push {rd, result_in} to the FIFO.
  - rd=0 ops are retired silently: no push, but their credit is returned.
- Credits:
  - inflight = number of valid tag stages; issue_ready = (occupancy + inflight) < FIFO_DEPTH.
  - issue_ready is combinational from registered state only (no path from issue_valid).
  - The adder's inability to stall is safe by construction: a push can never find the FIFO full.
  - If a push nevertheless finds the FIFO full (protocol violation), the push is dropped; an assertion fires in simulation.
- Writeback handshake:
  - wb_valid = occupancy≠0; wb_rd/wb_data show the head entry, stable while wb_valid & !wb_ready.
  - Pop at an edge where wb_valid & wb_ready.
  - Push and pop in the same edge: occupancy unchanged, data order preserved.
  - Push into an empty FIFO makes wb_valid=1 the cycle after the capture edge; there is no bypass.
  - When empty, wb_rd/wb_data hold their last values; their content is don't-care when wb_valid=0.
- Flush:
  - At the edge where flush=1, all tag-line v bits are cleared, including the op being accepted that edge, which is squashed.
  - The capture at that same edge still occurs: the op in stage DEPTH-1 is architecturally older and is committed.
  - FIFO contents are untouched. inflight becomes 0, so credits return the next cycle.
- Ordering: entries leave in issue order; no reordering or merging.
- Pointers wrap modulo FIFO_DEPTH; occupancy saturates in range 0..FIFO_DEPTH by construction.

Test Plan:
- Latency, rd≠0 (DEPTH=3): one op issued at edge 0 with rd=5 and adder result 0x0000_0007, wb_ready=1 → capture at edge 3; wb_valid=1 with wb_rd=5, wb_data=7 after edge 3; pop at edge 4; wb_valid=0 after edge 4.
- Back-pressure: wb_ready=0, issue_valid=1 every cycle, rd=1..6 (FIFO_DEPTH=4) → exactly 4 accepts at edges 0–3; issue_ready=0 from after edge 3.
  - occupancy reaches 4 after edge 6; issue_ready stays 0 while full.
  - Then wb_ready=1 → entries rd=1,2,3,4 popped in order; issue_ready=1 the cycle after the first pop.
- x0 discard: ops with rd=0, 3, 0 back-to-back → only rd=3 reaches writeback; all three credits return (issue_ready=1, occupancy=0 after drain).
- Flush mid-flight: issue rd=7 at edge 0 and rd=8 at edge 1; flush=1 at edge 2 → neither rd=7 nor rd=8 is ever written back; issue_ready=1 after edge 2.
  - Second case: flush at edge 3, the capture edge of the edge-0 op → the rd=7 op is still written back.
- Simultaneous push/pop: steady stream with wb_ready=1 → occupancy stays 1 and one entry per cycle is written back, in order.
- Async reset mid-operation: reset=0 asserted mid-cycle with 2 entries buffered and 2 ops in flight → wb_valid=0, occupancy=0, issue_ready=1 immediately, without waiting for a clock edge.
  - After release, no stale capture appears on wb_* over DEPTH+2 cycles.
